dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the RISC16 single-port data memory (16-bit words, combinational read, synchronous write) between the CPU load/store port and a debug/loader port. Grants at most one access per cycle, alternates fairly under contention, supports locked debug bursts with a bounded CPU starvation limit, and returns registered read data with a one-cycle `rvalid` pulse. Sits between the core datapath and `data_mem` in the top level. The CPU uses `cpu_stall` to hold its PC.

## Interface
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory data width.
- `LOCK_MAX`, default 16: maximum consecutive locked debug grants while the CPU is waiting (range 1..255).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `cpu_req`, input, 1: CPU requests an access this cycle.
- `cpu_we`, input, 1: 1 = write, 0 = read.
- `cpu_addr`, input, ADDR_W: word address.
- `cpu_wdata`, input, DATA_W: write data.
- `cpu_gnt`, output, 1: CPU access performed this cycle.
- `cpu_stall`, output, 1: `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`, output, 1: one-cycle pulse; `cpu_rdata` holds the result of the granted read.
- `cpu_rdata`, output, DATA_W: registered read data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same meanings as the CPU port.
- `dbg_lock`, input, 1: keep ownership after the current debug grant.
- `mem_we`, output, 1: write strobe to `data_mem`.
- `mem_addr`, output, ADDR_W: address to `data_mem`.
- `mem_wdata`, output, DATA_W: write data to `data_mem`.
- `mem_rdata`, input, DATA_W: combinational read data from `data_mem`.

## Operation
- **State registers:**
  - `owner` ∈ {NONE, DBG_LOCKED}.
  - `last` ∈ {CPU, DBG}: last port granted.
  - `lock_cnt`: 8-bit counter.
  - Per-port `rvalid` and `rdata` registers.
- **Grant selection (combinational from requests and state):**
  - `owner=DBG_LOCKED` and `dbg_req=1`: grant DBG, unless `cpu_req=1` and `lock_cnt==LOCK_MAX`. In that case grant CPU.
  - `owner=NONE`, single requester: grant it.
  - `owner=NONE`, both requesting: grant the port ≠ `last`.
  - No requests: no grant.
- **Memory mux:**
  - `mem_addr` and `mem_wdata` come from the granted port.
  - `mem_we = granted port's we`.
  - With no grant: `mem_addr=0`, `mem_wdata=0`, `mem_we=0`.
- **Owner transitions at the clock edge:**
  - NONE→DBG_LOCKED when DBG is granted with `dbg_lock=1`.
  - DBG_LOCKED→NONE when `dbg_req=0` or `dbg_lock=0`.
  - A forced CPU grant does not change `owner`.
- **`lock_cnt`:**
  - Increments (saturating at LOCK_MAX) on each locked DBG grant while `cpu_req=1`.
  - Clears on any CPU grant or on exiting DBG_LOCKED.
  - Holds otherwise.
- **`last`** updates to the granted port on every grant.
- **Reads:** on a granted read, `mem_rdata` is captured into that port's `rdata`. That port's `rvalid` is set for exactly the next cycle. `rdata` holds until the next granted read for that port.
- **Writes** commit in `data_mem` at the edge ending the grant cycle. A write produces no `rvalid`.

## Timing
- Grant latency is zero cycles: `gnt` can assert in the same cycle as `req`.
- Read latency is 1 cycle: grant in cycle N gives `rvalid`/`rdata` in cycle N+1.
- Back-to-back grants to one port give back-to-back `rvalid` pulses.
- Reset values:
  - `owner=NONE`, `last=DBG` (so the CPU wins the first contention), `lock_cnt=0`.
  - Both `rvalid=0`, both `rdata=0`.
  - `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - Both `gnt=0`; `cpu_stall` equals `cpu_req`.
  - All grants and `mem_we` are forced to 0 while `reset` is low.
- Reset mid-operation: `reset` low before an edge means no write commits and no pending `rvalid` survives.
- Requests held through a stall are serviced without being re-issued. Requesters keep address, data and `we` stable while stalled.
- A forced CPU grant at `lock_cnt==LOCK_MAX` clears `lock_cnt`. The next cycle returns to DBG if still locked.

## Test plan
- **CPU read alone:** `cpu_req=1, we=0, addr=0x0010`, memory word = `0xBEEF`. Required: `cpu_gnt=1` that cycle, `cpu_stall=0`, `mem_addr=0x0010`; next cycle `cpu_rvalid=1`, `cpu_rdata=0xBEEF`; `dbg_rvalid=0`.
- **Contention from reset:** both request reads for 4 cycles. Required: grants CPU, DBG, CPU, DBG; `cpu_stall=1` in cycles 2 and 4.
- **Write/read ordering:** DBG writes `0x1234` to `0x0005` in cycle N; CPU reads `0x0005` in cycle N+1. Required: `cpu_rdata=0x1234` at N+2.
- **Locked burst with `LOCK_MAX=4`:** `dbg_lock=1, dbg_req=1` held, `cpu_req=1`. Required pattern: DBG×5 (the first grant enters the lock), then CPU×1, then DBG resumes; `cpu_stall` is high during the DBG cycles.
- **Lock release:** `dbg_lock` drops with both requesting. Required: next cycle grants CPU and `owner` returns to NONE.
- **Async reset mid-write:** `reset` pulses low between edges during a granted DBG write. Required: `mem_we=0` immediately, the memory word is unchanged, all `rvalid=0`, `rdata=0`, and the first contention after release grants CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU load/store port and the
// debug/loader port: fair alternation, locked debug bursts with bounded CPU starvation.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic { OWN_NONE, OWN_DBG_LOCKED } owner_e;
    typedef enum logic { LAST_CPU, LAST_DBG } last_e;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    owner_e            owner_q, owner_d;
    last_e             last_q, last_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              lock_exit;

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (owner_q == OWN_DBG_LOCKED && dbg_req) begin
            // The CPU only breaks into a locked burst once it has waited LOCK_MAX grants.
            if (cpu_req && lock_cnt_q == LOCK_LIMIT) cpu_gnt = 1'b1;
            else                                     dbg_gnt = 1'b1;
        end else if (cpu_req && dbg_req) begin
            if (last_q == LAST_DBG) cpu_gnt = 1'b1;
            else                    dbg_gnt = 1'b1;
        end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
        end
        if (!reset) begin
            cpu_gnt = 1'b0;
            dbg_gnt = 1'b0;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        lock_exit  = (owner_q == OWN_DBG_LOCKED) && (!dbg_req || !dbg_lock);

        if (cpu_gnt)      last_d = LAST_CPU;
        else if (dbg_gnt) last_d = LAST_DBG;

        if (lock_exit)
            owner_d = OWN_NONE;
        else if (owner_q == OWN_NONE && dbg_gnt && dbg_lock)
            owner_d = OWN_DBG_LOCKED;

        // Only grants made while already locked count against the CPU's wait.
        if (lock_exit || cpu_gnt)
            lock_cnt_d = '0;
        else if (owner_q == OWN_DBG_LOCKED && dbg_gnt && cpu_req && lock_cnt_q < LOCK_LIMIT)
            lock_cnt_d = lock_cnt_q + 8'd1;

        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        dbg_rvalid_d = dbg_gnt & ~dbg_we;
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_NONE;
            last_q       <= LAST_DBG;
            lock_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            last_q       <= last_d;
            lock_cnt_q   <= lock_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts grants and read returns,
// a separate monitor pops expected reads whenever an rvalid appears.
module tb_dmem_arbiter;

    localparam int LMAX = 4;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] ram     [256];
    logic [15:0] ref_mem [256];
    rsp_t        rq [2][$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        if (i == 16'h10) return 16'hBEEF;
        if (i == 16'h20) return 16'hC0DE;
        return 16'(i * 16'h0101) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // data_mem stand-in: combinational read, write at the clock edge
    assign mem_rdata = ram[mem_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: evaluated mid-cycle once inputs and grants have settled.
    initial begin : model
        bit          locked, last_dbg, eg_c, eg_d, was_locked;
        int          waited;
        logic        e_we;
        logic [15:0] e_addr, e_wdata;
        rsp_t        r;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        locked = 0; last_dbg = 1; waited = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_cpu_gnt", cpu_gnt, 0);
                chk("rst_dbg_gnt", dbg_gnt, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_cpu_stall", cpu_stall, cpu_req);
                chk("rst_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
                chk("rst_cpu_rdata", cpu_rdata, 0);
                chk("rst_dbg_rdata", dbg_rdata, 0);
                locked = 0; last_dbg = 1; waited = 0;
                rq[0].delete();
                rq[1].delete();
            end else begin
                eg_c = 0; eg_d = 0;
                if (locked && dbg_req) begin
                    if (cpu_req && waited == LMAX) eg_c = 1;
                    else eg_d = 1;
                end else if (cpu_req && dbg_req) begin
                    if (last_dbg) eg_c = 1;
                    else eg_d = 1;
                end else begin
                    eg_c = cpu_req; eg_d = dbg_req;
                end
                e_we = 0; e_addr = 0; e_wdata = 0;
                if (eg_c) begin e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end
                if (eg_d) begin e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata; end
                chk("cpu_gnt", cpu_gnt, eg_c);
                chk("dbg_gnt", dbg_gnt, eg_d);
                chk("cpu_stall", cpu_stall, cpu_req & ~eg_c);
                chk("mem_bus", {15'd0, mem_we, mem_addr}, {15'd0, e_we, e_addr});
                chk("mem_wdata", mem_wdata, e_wdata);
                if ((eg_c || eg_d) && !e_we) begin
                    r.due = cyc + 1;
                    r.data = ref_mem[e_addr[7:0]];
                    rq[eg_d ? 1 : 0].push_back(r);
                end
                if ((eg_c || eg_d) && e_we) ref_mem[e_addr[7:0]] = e_wdata;
                if (eg_c) last_dbg = 0;
                if (eg_d) last_dbg = 1;
                was_locked = locked;
                if (was_locked && (!dbg_req || !dbg_lock)) begin
                    locked = 0; waited = 0;
                end else begin
                    if (!was_locked && eg_d && dbg_lock) locked = 1;
                    if (eg_c) waited = 0;
                    else if (was_locked && eg_d && cpu_req && waited < LMAX) waited++;
                end
            end
        end
    end

    // Monitor: consumes the scoreboard whenever a port presents rvalid.
    initial begin : monitor
        logic [15:0] held [2];
        logic        v;
        logic [15:0] d;
        rsp_t        e;
        held[0] = 0; held[1] = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held[0] = 0; held[1] = 0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    v = (p == 1) ? dbg_rvalid : cpu_rvalid;
                    d = (p == 1) ? dbg_rdata : cpu_rdata;
                    if (v) begin
                        if (rq[p].size() != 0 && rq[p][0].due == cyc) begin
                            e = rq[p].pop_front();
                            chk(p == 1 ? "dbg_rdata" : "cpu_rdata", d, e.data);
                            held[p] = e.data;
                        end else begin
                            chk(p == 1 ? "dbg_rvalid_spurious" : "cpu_rvalid_spurious", v, 0);
                        end
                    end else if (rq[p].size() != 0 && rq[p][0].due <= cyc) begin
                        void'(rq[p].pop_front());
                        chk(p == 1 ? "dbg_rvalid_missing" : "cpu_rvalid_missing", v, 1);
                    end else begin
                        chk(p == 1 ? "dbg_rdata_hold" : "cpu_rdata_hold", d, held[p]);
                    end
                end
            end
        end
    end

    task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                        input logic dl, output logic [1:0] g);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = dl;
        #3;
        g = {dbg_gnt, cpu_gnt};
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [1:0] g;
        logic [7:0] pat;
        logic       hc, hd;
        int         mode;

        cpu_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        pat = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h1, 0, 1, 0, 16'h2, 0, 0, g);
            pat[2*i +: 2] = g;
        end
        chk("contention_order", pat, 8'b10_01_10_01);

        step(1, 0, 16'h10, 0, 0, 0, 0, 0, 0, g);
        chk("cpu_read_rvalid", {dbg_rvalid, cpu_rvalid}, 2'b01);
        chk("cpu_read_data", cpu_rdata, 16'hBEEF);

        step(0, 0, 0, 0, 1, 1, 16'h5, 16'h1234, 0, g);
        step(1, 0, 16'h5, 0, 0, 0, 0, 0, 0, g);
        chk("write_then_read", cpu_rdata, 16'h1234);

        pat = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 16'h3, 0, 1, 0, 16'(i), 0, 1, g);
            pat[i] = g[1];
        end
        chk("lock_burst_pattern", pat, 8'b1101_1111);

        step(1, 0, 16'h3, 0, 1, 0, 16'h4, 0, 0, g);
        step(1, 0, 16'h10, 0, 1, 0, 16'h4, 0, 0, g);
        chk("release_grants_cpu", g, 2'b01);

        cpu_req = 0; cpu_we = 0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h20; dbg_wdata = 16'hAAAA; dbg_lock = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_mem_we", mem_we, 0);
        chk("midreset_dbg_gnt", dbg_gnt, 0);
        chk("midreset_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
        chk("midreset_cpu_rdata", cpu_rdata, 0);
        dbg_req = 0; dbg_we = 0;
        @(posedge clk);
        #1;
        chk("midreset_no_commit", ram[8'h20], 16'hC0DE);
        reset = 1'b1;
        step(1, 0, 16'h20, 0, 1, 0, 16'h21, 0, 0, g);
        chk("post_reset_cpu_first", g, 2'b01);

        hc = 0; hd = 0; mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) mode = $urandom_range(0, 2);
            if (!hc) begin
                cpu_req   = $urandom_range(0, 9) < (mode == 0 ? 4 : 8);
                cpu_we    = $urandom_range(0, 2) == 0;
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            if (!hd) begin
                dbg_req   = (mode == 2) ? ($urandom_range(0, 19) != 0)
                                        : ($urandom_range(0, 9) < (mode == 0 ? 3 : 8));
                dbg_we    = $urandom_range(0, 2) == 0;
                dbg_addr  = 16'($urandom_range(0, 15));
                dbg_wdata = 16'($urandom);
            end
            dbg_lock = (mode == 2) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 4) == 0);
            #3;
            hc = cpu_stall;
            hd = dbg_req & ~dbg_gnt;
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        chk("scoreboard_drained", rq[0].size() + rq[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
